mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single unified instruction/data memory of the multicycle core. It shares the memory between requester 0 (core control/datapath) and requester 1 (program loader/debug port). It serialises their accesses, drives the memory strobe and address/data, waits out the memory read latency, and returns a registered acknowledge plus read data to the winning requester. It sits between the core's memory-address mux and the memory macro.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_if.sv | 28 ++
 rtl/rr_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the unified-memory arbiter
package mem_arb_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam int PORT_CORE = 0;
   localparam int PORT_LOAD = 1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester and memory-side signals of the arbiter
interface mem_arb_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata;
   logic [1:0]    gnt;
   logic          busy;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way winner pick, fixed core priority or round-robin
module rr_pick2
   import mem_arb_pkg::*;
#(
   parameter int CORE_PRIORITY = 0
) (
   input  logic       req0,
   input  logic       req1,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req0 && req1) begin
         // On a tie the port that did not win last time goes next
         if (CORE_PRIORITY != 0 || last_gnt == 1'(PORT_LOAD))
            gnt[PORT_CORE] = 1'b1;
         else
            gnt[PORT_LOAD] = 1'b1;
      end else if (req0) begin
         gnt[PORT_CORE] = 1'b1;
      end else if (req1) begin
         gnt[PORT_LOAD] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and access sequencer for the unified memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW            = 8,
   parameter int DW            = 32,
   parameter int MEM_LAT       = 1,
   parameter int CORE_PRIORITY = 0
) (
   input logic clk,
   input logic reset,
   mem_arb_if.slave bus
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT out of range");
   end

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   logic [1:0]    state;
   logic [2:0]    cnt, cnt_next;
   logic          last_gnt;
   logic [1:0]    pick;
   logic [1:0]    gnt_q;
   logic          ack0_q, ack1_q;
   logic [DW-1:0] rdata_q;
   logic          mem_en_q, mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic          done;

   rr_pick2 #(.CORE_PRIORITY(CORE_PRIORITY)) u_pick (
      .req0     (bus.req0),
      .req1     (bus.req1),
      .last_gnt (last_gnt),
      .gnt      (pick)
   );

   // Counter reaching 1 marks the edge at which read data is captured
   always_comb begin
      cnt_next = (state == ISSUE) ? LAT : cnt - 3'd1;
      done     = (state == ISSUE || state == WAIT) && (cnt_next == 3'd1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         last_gnt    <= 1'(PORT_LOAD);
         gnt_q       <= 2'b00;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_en_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick != 2'b00) begin
                  gnt_q       <= pick;
                  last_gnt    <= pick[PORT_LOAD];
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= pick[PORT_LOAD] ? bus.we1    : bus.we0;
                  mem_addr_q  <= pick[PORT_LOAD] ? bus.addr1  : bus.addr0;
                  mem_wdata_q <= pick[PORT_LOAD] ? bus.wdata1 : bus.wdata0;
                  state       <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               cnt <= cnt_next;
               if (done) begin
                  rdata_q <= bus.mem_rdata;
                  ack0_q  <= gnt_q[PORT_CORE];
                  ack1_q  <= gnt_q[PORT_LOAD];
                  state   <= RESP;
               end else begin
                  state   <= WAIT;
               end
            end
            RESP: begin
               gnt_q <= 2'b00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata     = rdata_q;
   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state != IDLE);
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_arb_if #(.AW(8), .DW(32)) ifa ();
   mem_arb_if #(.AW(8), .DW(32)) ifb ();
   mem_arb_if #(.AW(8), .DW(32)) ifc ();

   mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(1), .CORE_PRIORITY(0)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(3), .CORE_PRIORITY(1)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));
   mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(4), .CORE_PRIORITY(0)) dut_c (
      .clk(clk), .reset(reset), .bus(ifc.slave));

   function automatic logic [31:0] mem_init(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A5A5, a};
   endfunction

   // Memory models: read data follows the held address; B also stores writes
   logic [31:0]  mem_b [256];
   logic [255:0] mem_b_vld;
   always @(posedge clk) begin
      if (reset) mem_b_vld <= '0;
      else if (ifb.mem_en && ifb.mem_we) begin
         mem_b[ifb.mem_addr]     <= ifb.mem_wdata;
         mem_b_vld[ifb.mem_addr] <= 1'b1;
      end
   end
   assign ifa.mem_rdata = mem_init(ifa.mem_addr);
   assign ifb.mem_rdata = mem_b_vld[ifb.mem_addr] ? mem_b[ifb.mem_addr] : mem_init(ifb.mem_addr);
   assign ifc.mem_rdata = mem_init(ifc.mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int seq [4];
   int at  [4];
   logic [31:0] rd [4];
   int na, n0, nack;

   initial begin
      {ifa.req0, ifa.req1, ifa.we0, ifa.we1} = '0;
      {ifb.req0, ifb.req1, ifb.we0, ifb.we1} = '0;
      {ifc.req0, ifc.req1, ifc.we0, ifc.we1} = '0;
      {ifa.addr0, ifa.addr1, ifb.addr0, ifb.addr1, ifc.addr0, ifc.addr1} = '0;
      {ifa.wdata0, ifa.wdata1, ifb.wdata0, ifb.wdata1, ifc.wdata0, ifc.wdata1} = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_ctl",   32'({ifa.ack0, ifa.ack1, ifa.gnt, ifa.busy, ifa.mem_en, ifa.mem_we}), 32'h0);
      check("rst_rdata", ifa.rdata, 32'h0);
      check("rst_addr",  32'(ifa.mem_addr), 32'h0);
      check("rst_wdata", ifa.mem_wdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Single read, MEM_LAT=1
      ifa.req0 = 1'b1; ifa.addr0 = 8'h10;
      check("rd_idle_busy", 32'(ifa.busy), 32'h0);
      @(negedge clk);
      check("rd_mem_en",  32'(ifa.mem_en), 32'h1);
      check("rd_mem_addr", 32'(ifa.mem_addr), 32'h10);
      check("rd_gnt",     32'(ifa.gnt), 32'h1);
      check("rd_busy",    32'(ifa.busy), 32'h1);
      check("rd_ack1_a",  32'(ifa.ack1), 32'h0);
      @(negedge clk);
      check("rd_ack0",    32'(ifa.ack0), 32'h1);
      check("rd_rdata",   ifa.rdata, 32'hDEADBEEF);
      check("rd_mem_en_off", 32'(ifa.mem_en), 32'h0);
      check("rd_ack1_b",  32'(ifa.ack1), 32'h0);
      ifa.req0 = 1'b0;
      @(negedge clk);
      check("rd_ack0_off", 32'(ifa.ack0), 32'h0);
      check("rd_idle_gnt", 32'({ifa.gnt, ifa.busy}), 32'h0);
      check("rd_ack1_c",  32'(ifa.ack1), 32'h0);

      // Write then read, MEM_LAT=3
      ifb.req1 = 1'b1; ifb.we1 = 1'b1; ifb.addr1 = 8'h2A; ifb.wdata1 = 32'h12345678;
      @(negedge clk);
      check("wr_mem_en",  32'(ifb.mem_en), 32'h1);
      check("wr_mem_we",  32'(ifb.mem_we), 32'h1);
      check("wr_addr",    32'(ifb.mem_addr), 32'h2A);
      check("wr_wdata",   ifb.mem_wdata, 32'h12345678);
      check("wr_gnt",     32'(ifb.gnt), 32'h2);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("wr_ack1_t%0d", i), 32'(ifb.ack1), (i == 4) ? 32'h1 : 32'h0);
      end
      ifb.req1 = 1'b0; ifb.we1 = 1'b0;
      @(negedge clk);
      check("wr_back_idle", 32'(ifb.busy), 32'h0);
      ifb.req0 = 1'b1; ifb.addr0 = 8'h2A;
      @(negedge clk);
      check("rb_mem_we", 32'(ifb.mem_we), 32'h0);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("rb_ack0_t%0d", i), 32'(ifb.ack0), (i == 4) ? 32'h1 : 32'h0);
      end
      check("rb_rdata", ifb.rdata, 32'h12345678);
      ifb.req0 = 1'b0;

      // Tie, round-robin on A (MEM_LAT=1): alternate, spaced MEM_LAT+2
      reset = 1'b1;
      ifa.req0 = 1'b1; ifa.addr0 = 8'h01;
      ifa.req1 = 1'b1; ifa.addr1 = 8'h02;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin seq[k] = -1; at[k] = -1; rd[k] = '0; end
      na = 0;
      for (int i = 1; i <= 40 && na < 4; i++) begin
         @(negedge clk);
         if (ifa.ack0 || ifa.ack1) begin
            seq[na] = ifa.ack1 ? 1 : 0; at[na] = i; rd[na] = ifa.rdata; na++;
         end
      end
      ifa.req0 = 1'b0; ifa.req1 = 1'b0;
      check("rr_first_at", 32'(at[0]), 32'd2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_port%0d", k), 32'(seq[k]), (k % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("rr_rdata%0d", k), rd[k], (k % 2 == 1) ? 32'hA5A5A502 : 32'hA5A5A501);
         if (k > 0) check($sformatf("rr_space%0d", k), 32'(at[k] - at[k-1]), 32'd3);
      end

      // Tie, CORE_PRIORITY=1 on B: three port-0 acks before port 1
      reset = 1'b1;
      ifb.req0 = 1'b1; ifb.addr0 = 8'h05;
      ifb.req1 = 1'b1; ifb.we1 = 1'b0; ifb.addr1 = 8'h06;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) seq[k] = -1;
      na = 0; n0 = 0;
      for (int i = 1; i <= 60 && na < 4; i++) begin
         @(negedge clk);
         if (ifb.ack0) begin
            seq[na] = 0; na++; n0++;
            if (n0 == 3) ifb.req0 = 1'b0;
         end else if (ifb.ack1) begin
            seq[na] = 1; na++;
         end
      end
      ifb.req0 = 1'b0; ifb.req1 = 1'b0;
      for (int k = 0; k < 4; k++)
         check($sformatf("pri_port%0d", k), 32'(seq[k]), (k == 3) ? 32'd1 : 32'd0);

      // Reset during WAIT, MEM_LAT=4
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      ifc.req0 = 1'b1; ifc.addr0 = 8'h33;
      @(negedge clk);
      check("rw_mem_en", 32'(ifc.mem_en), 32'h1);
      @(negedge clk);
      check("rw_busy", 32'(ifc.busy), 32'h1);
      @(negedge clk);
      check("rw_ack0_pre", 32'(ifc.ack0), 32'h0);
      reset = 1'b1; ifc.req0 = 1'b0;
      @(negedge clk);
      check("rw_ctl",   32'({ifc.ack0, ifc.ack1, ifc.gnt, ifc.busy, ifc.mem_en, ifc.mem_we}), 32'h0);
      check("rw_rdata", ifc.rdata, 32'h0);
      check("rw_addr",  32'(ifc.mem_addr), 32'h0);
      check("rw_wdata", ifc.mem_wdata, 32'h0);
      reset = 1'b0;
      nack = 0;
      repeat (4) begin
         @(negedge clk);
         if (ifc.ack0 || ifc.ack1) nack++;
      end
      check("rw_no_ack", 32'(nack), 32'h0);
      ifc.req1 = 1'b1; ifc.addr1 = 8'h44;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("rw_ack1_t%0d", i), 32'(ifc.ack1), (i == 5) ? 32'h1 : 32'h0);
      end
      check("rw_rdata1", ifc.rdata, 32'hA5A5A544);
      ifc.req1 = 1'b0;
      @(negedge clk);
      check("rw_idle", 32'(ifc.busy), 32'h0);

      // Early req drop during WAIT
      ifc.req0 = 1'b1; ifc.addr0 = 8'h10;
      repeat (2) @(negedge clk);
      ifc.req0 = 1'b0;
      for (int i = 3; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("ed_ack0_t%0d", i), 32'(ifc.ack0), (i == 5) ? 32'h1 : 32'h0);
      end
      check("ed_rdata", ifc.rdata, 32'hDEADBEEF);
      @(negedge clk);
      check("ed_idle", 32'({ifc.gnt, ifc.busy, ifc.ack0}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
